fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
- Drives the fetch stage PC register in the 8-bit pipelined datapath.
- Chooses the next PC: sequential, jump target from ID, or branch target from EX.
- Detects load-use hazards and stalls the front end for one cycle.
- Handles halt/resume, drives flush/stall controls for the IF/ID and ID/EX stage registers, and keeps saturating performance counters.

Parameters:
- PC_WIDTH, 8, width of PC and targets.
- REG_ADDR_WIDTH, 5, register-specifier width.
- COUNT_WIDTH, 16, width of performance counters.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high.
- pcCurrent  input  PC_WIDTH  current PC (output of fetch PC register).
- idRs, idRt  input  REG_ADDR_WIDTH each  source registers of instruction in ID.
- idJump  input  1  ID instruction is an unconditional jump.
- jumpTarget  input  PC_WIDTH  jump destination.
- idHalt  input  1  ID instruction is HALT.
- exMemRead  input  1  EX instruction is a load.
- exRd  input  REG_ADDR_WIDTH  EX destination register.
- branchTaken  input  1  EX resolved a taken branch.
- branchTarget  input  PC_WIDTH  branch destination.
- resume  input  1  debug request to leave HALTED.
- pcNext  output  PC_WIDTH  value presented to the fetch PC register (combinational).
- feNotEnable  output  1  active-high hold of the fetch PC register (combinational).
- ifidNotEnable  output  1  hold IF/ID register (combinational).
- ifidFlush  output  1  load bubble into IF/ID (combinational).
- idexFlush  output  1  load bubble into ID/EX (combinational).
- halted  output  1  state==HALTED.
- stallCycles  output  COUNT_WIDTH  cycles with feNotEnable=1, saturating.
- redirectCount  output  COUNT_WIDTH  branch+jump redirects, saturating.

Behaviour:
- States: RUN, STALL, HALTED. Reset: state RUN, counters 0, halted 0.
- Combinational outputs follow the RUN rules below while reset is asserted.
- Defaults: pcNext = pcCurrent+1, modulo 2^PC_WIDTH (8'hFF -> 8'h00); all control outputs 0.
- loadUse = exMemRead && exRd!=0 && (exRd==idRs || exRd==idRt).
- RUN, evaluated in priority order:
  1. branchTaken: pcNext=branchTarget; ifidFlush=1; idexFlush=1; redirectCount++; stay RUN. Overrides loadUse, idJump and idHalt in the same cycle.
  2. loadUse: feNotEnable=1; ifidNotEnable=1; idexFlush=1; next STALL.
  3. idJump: pcNext=jumpTarget; ifidFlush=1; redirectCount++; stay RUN.
  4. idHalt: feNotEnable=1; ifidNotEnable=1; idexFlush=1; next HALTED.
- STALL (exactly one cycle):
  - loadUse is not re-evaluated; fetch is enabled.
  - branchTaken and idJump are handled as in RUN.
  - Default pcNext applies.
  - Next state RUN, unless idHalt without branchTaken or idJump, in which case apply the halt actions and go to HALTED.
- HALTED:
  - feNotEnable=1, ifidNotEnable=1, idexFlush=1 every cycle; halted=1.
  - branchTaken is ignored (EX holds only bubbles).
  - On resume: feNotEnable=0, pcNext=pcCurrent+1, ifidFlush=1 (discards the HALT), next RUN.
  - halted deasserts the cycle after resume.
- Counters:
  - stallCycles increments on every clock edge where feNotEnable=1.
  - Both counters hold at all-ones, no wrap.
  - A redirect increments redirectCount by exactly 1, even if branchTaken and idJump are both set.
- Reset asserted mid-operation (STALL or HALTED) returns to RUN immediately, asynchronously.
- All state changes occur on the rising clock edge; pcNext and control outputs respond within the same cycle.

Test Plan:
- Sequential fetch: pcCurrent=8'hFE, no events -> pcNext=8'hFF. Then pcCurrent=8'hFF -> pcNext=8'h00; feNotEnable=0.
- Load-use: exMemRead=1, exRd=3, idRt=3 -> feNotEnable=1, ifidNotEnable=1, idexFlush=1 for one cycle. Next cycle in STALL with the same inputs -> feNotEnable=0. stallCycles=1. Repeat with exRd=0 -> no stall.
- Branch beats stall: branchTaken=1, branchTarget=8'h40, loadUse also true -> pcNext=8'h40, ifidFlush=1, idexFlush=1, feNotEnable=0. State stays RUN; redirectCount=1.
- Jump: idJump=1, jumpTarget=8'h10 -> pcNext=8'h10, ifidFlush=1, idexFlush=0.
- Halt/resume: idHalt=1 at pcCurrent=8'h21 -> halted=1 next cycle. Hold 5 cycles with feNotEnable=1 -> stallCycles=6. Pulse resume -> pcNext=8'h22, ifidFlush=1; halted=0 the following cycle.
- Reset mid-HALTED plus saturation:
  - Assert reset between clock edges in HALTED -> halted=0 immediately and counters=0.
  - Force 65535 stall cycles, then one more -> stallCycles stays 16'hFFFF.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: next-PC selection, load-use stall, halt/resume and front-end flush/stall control
//   clock, reset                     rising-edge clock, asynchronous active-high reset
//   pcCurrent                        current fetch PC
//   idRs, idRt, idJump, jumpTarget   ID-stage sources and jump request
//   idHalt                           ID instruction is HALT
//   exMemRead, exRd                  EX-stage load and its destination
//   branchTaken, branchTarget        EX-stage resolved taken branch
//   resume                           debug request to leave HALTED
//   pcNext, feNotEnable              next PC and fetch PC hold
//   ifidNotEnable, ifidFlush         IF/ID hold and bubble insert
//   idexFlush                        ID/EX bubble insert
//   halted                           sequencer is in HALTED
//   stallCycles, redirectCount       saturating performance counters
module fetch_sequencer #(
  parameter int PC_WIDTH       = 8,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [PC_WIDTH-1:0]       pcCurrent,
  input  logic [REG_ADDR_WIDTH-1:0] idRs,
  input  logic [REG_ADDR_WIDTH-1:0] idRt,
  input  logic                      idJump,
  input  logic [PC_WIDTH-1:0]       jumpTarget,
  input  logic                      idHalt,
  input  logic                      exMemRead,
  input  logic [REG_ADDR_WIDTH-1:0] exRd,
  input  logic                      branchTaken,
  input  logic [PC_WIDTH-1:0]       branchTarget,
  input  logic                      resume,
  output logic [PC_WIDTH-1:0]       pcNext,
  output logic                      feNotEnable,
  output logic                      ifidNotEnable,
  output logic                      ifidFlush,
  output logic                      idexFlush,
  output logic                      halted,
  output logic [COUNT_WIDTH-1:0]    stallCycles,
  output logic [COUNT_WIDTH-1:0]    redirectCount
);
  typedef enum logic [1:0] {RUN, STALL, HALTED} state_t;
  state_t state, state_next;
  logic load_use, in_run, in_halt;
  logic do_branch, do_jump, do_stall, do_halt, do_hold, do_resume;
  assign load_use = exMemRead && exRd != '0 && (exRd == idRs || exRd == idRt);
  assign in_run   = state == RUN;
  assign in_halt  = state == HALTED;
  // Priority decode: branch > load-use (RUN only) > jump > halt; HALTED ignores all redirects.
  always_comb begin
    do_branch = !in_halt && branchTaken;
    do_stall  = in_run && !branchTaken && load_use;
    do_jump   = !in_halt && !branchTaken && !do_stall && idJump;
    do_halt   = !in_halt && !branchTaken && !do_stall && !idJump && idHalt;
    do_resume = in_halt && resume;
    do_hold   = in_halt && !resume;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= RUN;
    else state <= state_next;
  always_comb
    state_next = in_halt ? (resume ? RUN : HALTED) : do_stall ? STALL : do_halt ? HALTED : RUN;
  always_comb begin
    pcNext        = do_branch ? branchTarget : do_jump ? jumpTarget : pcCurrent + PC_WIDTH'(1);
    feNotEnable   = do_stall || do_halt || do_hold;
    ifidNotEnable = do_stall || do_halt || do_hold;
    // On resume the HALT sitting in IF/ID is replaced by a bubble, so the register must load.
    ifidFlush     = do_branch || do_jump || do_resume;
    idexFlush     = do_branch || do_stall || do_halt || in_halt;
  end
  assign halted = in_halt;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      stallCycles   <= '0;
      redirectCount <= '0;
    end else begin
      if (feNotEnable && stallCycles != '1) stallCycles <= stallCycles + COUNT_WIDTH'(1);
      if ((do_branch || do_jump) && redirectCount != '1) redirectCount <= redirectCount + COUNT_WIDTH'(1);
    end
endmodule
